// File: rtl/inst_pipe_ctrl.sv
// Instruction-word pipeline control for a 5-stage RV32I core.
// Holds the IF/ID, ID/EX, EX/MEM and MEM/WB instruction registers, detects load-use
// hazards, inserts bubbles, applies branch flushes and memory freezes, and keeps
// saturating stall/flush event counters.
module inst_pipe_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,       // synchronous, active-high
    input  logic [31:0]      if_inst,
    input  logic             if_valid,
    input  logic             mem_ready,
    input  logic             flush_ex,
    output logic [31:0]      I2,
    output logic [31:0]      I3,
    output logic [31:0]      I4,
    output logic [31:0]      I5,
    output logic             pc_we,
    output logic             stall_lu,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_i2, r_i3, r_i4, r_i5;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic [6:0] w_i2_op;
    logic [6:0] w_i3_op;
    logic [4:0] w_i3_rd;
    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic       w_hazard;
    logic       w_stall_lu;

    assign w_i2_op = r_i2[6:0];
    assign w_i3_op = r_i3[6:0];
    assign w_i3_rd = r_i3[11:7];

    // Decode which source registers the instruction in IF/ID actually reads.
    always_comb begin
        w_uses_rs1 = !((w_i2_op == OpLui) || (w_i2_op == OpAuipc) || (w_i2_op == OpJal));
        w_uses_rs2 = (w_i2_op == OpReg) || (w_i2_op == OpStore) || (w_i2_op == OpBr);
        w_hazard   = (w_uses_rs1 && (r_i2[19:15] == w_i3_rd)) ||
                     (w_uses_rs2 && (r_i2[24:20] == w_i3_rd));
        // A load to x0 produces nothing to wait for, so bubbles never trigger a stall.
        w_stall_lu = (w_i3_op == OpLoad) && (w_i3_rd != 5'd0) && w_hazard;
    end

    assign stall_lu  = w_stall_lu;
    assign pc_we     = mem_ready & (flush_ex | ~w_stall_lu);
    assign I2        = r_i2;
    assign I3        = r_i3;
    assign I4        = r_i4;
    assign I5        = r_i5;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // Pipeline advance with priority: reset, freeze, flush, load-use bubble, normal advance.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_i2        <= NOP_INST;
            r_i3        <= NOP_INST;
            r_i4        <= NOP_INST;
            r_i5        <= NOP_INST;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_ready) begin
            r_i2 <= r_i2;
        end else if (flush_ex) begin
            // Any concurrent load-use stall is moot: the dependent instruction is squashed.
            r_i2 <= NOP_INST;
            r_i3 <= NOP_INST;
            r_i4 <= r_i3;
            r_i5 <= r_i4;
            if (r_flush_cnt != CntMax) begin
                r_flush_cnt <= r_flush_cnt + CntOne;
            end
        end else if (w_stall_lu) begin
            r_i3 <= NOP_INST;
            r_i4 <= r_i3;
            r_i5 <= r_i4;
            if (r_stall_cnt != CntMax) begin
                r_stall_cnt <= r_stall_cnt + CntOne;
            end
        end else begin
            r_i2 <= if_valid ? if_inst : NOP_INST;
            r_i3 <= r_i2;
            r_i4 <= r_i3;
            r_i5 <= r_i4;
        end
    end

endmodule

// File: tb/tb_inst_pipe_ctrl.sv
// Self-checking bench for inst_pipe_ctrl: directed vector table, hand-written
// saturation/reset sequence, then randomized traffic against a behavioural model.
module tb_inst_pipe_ctrl;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] LW5  = 32'h0000A283;  // lw x5,0(x1)
    localparam logic [31:0] ADD  = 32'h00728333;  // add x6,x5,x7
    localparam logic [31:0] LW0  = 32'h0000A003;  // lw x0,0(x1)
    localparam logic [31:0] LUI  = 32'h000052B7;  // lui x5,0x5
    localparam logic [31:0] LUI2 = 32'h000282B7;  // lui x5,0x28 (rs1 field happens to be 5)
    localparam logic [31:0] JNK  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] if_inst = '0;
    logic        if_valid = 1'b0;
    logic        mem_ready = 1'b1;
    logic        flush_ex = 1'b0;

    logic [31:0] I2, I3, I4, I5;
    logic        pc_we, stall_lu;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_i2, s_i3, s_i4, s_i5;
    logic        s_pc_we, s_stall_lu;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_pipe_ctrl u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .mem_ready (mem_ready),
        .flush_ex  (flush_ex),
        .I2        (I2),
        .I3        (I3),
        .I4        (I4),
        .I5        (I5),
        .pc_we     (pc_we),
        .stall_lu  (stall_lu),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation checks.
    inst_pipe_ctrl #(.CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rstn      (rstn),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .mem_ready (mem_ready),
        .flush_ex  (flush_ex),
        .I2        (s_i2),
        .I3        (s_i3),
        .I4        (s_i4),
        .I5        (s_i5),
        .pc_we     (s_pc_we),
        .stall_lu  (s_stall_lu),
        .stall_cnt (s_stall_cnt),
        .flush_cnt (s_flush_cnt)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_pipe [2:5];
    int          m_stalls, m_flushes;
    logic        m_stall, m_pcwe;
    logic        c_stall, c_pcwe;  // DUT combinational outputs sampled before the edge

    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        logic [6:0] op;
        bit rs1_used, rs2_used;
        op = w[6:0];
        rs1_used = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        rs2_used = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (rs1_used && w[19:15] == r) || (rs2_used && w[24:20] == r);
    endfunction

    function automatic bit load_use(input logic [31:0] younger, input logic [31:0] load);
        if (load[6:0] != 7'b0000011 || load[11:7] == 5'd0) return 1'b0;
        return reads_reg(younger, load[11:7]);
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step(input bit rst, input logic [31:0] inst, input bit valid,
                              input bit mr, input bit fl);
        if (rst) begin
            for (int k = 2; k <= 5; k++) m_pipe[k] = NOP;
            m_stalls  = 0;
            m_flushes = 0;
        end else if (!mr) begin
            // frozen
        end else if (fl || m_stall) begin
            m_pipe[5] = m_pipe[4];
            m_pipe[4] = m_pipe[3];
            m_pipe[3] = NOP;
            if (fl) begin
                m_pipe[2] = NOP;
                m_flushes++;
            end else begin
                m_stalls++;
            end
        end else begin
            m_pipe[5] = m_pipe[4];
            m_pipe[4] = m_pipe[3];
            m_pipe[3] = m_pipe[2];
            m_pipe[2] = valid ? inst : NOP;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample combinational outputs, clock, settle.
    task automatic do_cycle(input bit rst, input logic [31:0] inst, input bit valid,
                            input bit mr, input bit fl);
        @(negedge clk);
        rstn      = rst;
        if_inst   = inst;
        if_valid  = valid;
        mem_ready = mr;
        flush_ex  = fl;
        #1;
        c_stall = stall_lu;
        c_pcwe  = pc_we;
        m_stall = load_use(m_pipe[2], m_pipe[3]);
        m_pcwe  = mr & (fl | ~m_stall);
        @(posedge clk);
        #1;
        model_step(rst, inst, valid, mr, fl);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".stall_lu"}, {31'd0, c_stall}, {31'd0, m_stall});
        chk({tag, ".pc_we"},    {31'd0, c_pcwe},  {31'd0, m_pcwe});
        chk({tag, ".I2"}, I2, m_pipe[2]);
        chk({tag, ".I3"}, I3, m_pipe[3]);
        chk({tag, ".I4"}, I4, m_pipe[4]);
        chk({tag, ".I5"}, I5, m_pipe[5]);
        chk({tag, ".stall_cnt"},  {16'd0, stall_cnt},   32'(sat(m_stalls, 16)));
        chk({tag, ".flush_cnt"},  {16'd0, flush_cnt},   32'(sat(m_flushes, 16)));
        chk({tag, ".stall_cnt4"}, {28'd0, s_stall_cnt}, 32'(sat(m_stalls, 4)));
        chk({tag, ".flush_cnt4"}, {28'd0, s_flush_cnt}, 32'(sat(m_flushes, 4)));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] inst;
        logic        valid, mr, fl;
        logic        e_stall, e_pcwe;
        logic [31:0] e2, e3, e4, e5;
        int          e_sc, e_fc;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [8];
        logic [6:0] op;
        logic [31:0] w;
        ops = '{7'b0000011, 7'b0000011, 7'b0110011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b1101111, 7'b0010011};
        op = ops[$urandom_range(0, 7)];
        w = $urandom;
        // Small register numbers make dependencies frequent.
        w[24:20] = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[11:7]  = 5'($urandom_range(0, 3));
        w[6:0]   = op;
        return w;
    endfunction

    initial begin
        for (int k = 2; k <= 5; k++) m_pipe[k] = '0;
        m_stalls = 0;
        m_flushes = 0;

        // Reset held 2 cycles with random inputs.
        for (int c = 0; c < 2; c++) begin
            do_cycle(1'b1, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            chk("reset.pc_we", {31'd0, c_pcwe}, {31'd0, m_pcwe});
            chk("reset.I2", I2, NOP);
            chk("reset.I3", I3, NOP);
            chk("reset.I4", I4, NOP);
            chk("reset.I5", I5, NOP);
            chk("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
            chk("reset.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        end

        //            inst  v     mr    fl    stall pcwe  I2    I3    I4    I5   sc fc
        vq.push_back('{LW5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LW5,  NOP,  NOP,  NOP, 0, 0});
        vq.push_back('{ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ADD,  LW5,  NOP,  NOP, 0, 0});
        vq.push_back('{JNK, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ADD,  NOP,  LW5,  NOP, 1, 0});
        vq.push_back('{JNK, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, NOP,  ADD,  NOP,  LW5, 1, 0});
        vq.push_back('{LW0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LW0,  NOP,  ADD,  NOP, 1, 0});
        vq.push_back('{ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ADD,  LW0,  NOP,  ADD, 1, 0});
        vq.push_back('{LUI, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LUI,  ADD,  LW0,  NOP, 1, 0});
        vq.push_back('{LW5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LW5,  LUI,  ADD,  LW0, 1, 0});
        vq.push_back('{LUI2,1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LUI2, LW5,  LUI,  ADD, 1, 0});
        vq.push_back('{NOP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, NOP,  LUI2, LW5,  LUI, 1, 0});
        vq.push_back('{LW5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LW5,  NOP,  LUI2, LW5, 1, 0});
        vq.push_back('{ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ADD,  LW5,  NOP,  LUI2,1, 0});
        vq.push_back('{JNK, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, NOP,  NOP,  LW5,  NOP, 1, 1});
        vq.push_back('{ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ADD,  NOP,  NOP,  LW5, 1, 1});
        vq.push_back('{LW5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, LW5,  ADD,  NOP,  NOP, 1, 1});
        vq.push_back('{JNK, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, LW5,  ADD,  NOP,  NOP, 1, 1});
        vq.push_back('{ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, LW5,  ADD,  NOP,  NOP, 1, 1});
        vq.push_back('{LW5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, LW5,  ADD,  NOP,  NOP, 1, 1});
        vq.push_back('{JNK, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, NOP,  NOP,  ADD,  NOP, 1, 2});
        vq.push_back('{NOP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, NOP,  NOP,  NOP,  ADD, 1, 2});

        foreach (vq[i]) begin
            do_cycle(1'b0, vq[i].inst, vq[i].valid, vq[i].mr, vq[i].fl);
            chk($sformatf("vec%0d.stall_lu", i), {31'd0, c_stall}, {31'd0, vq[i].e_stall});
            chk($sformatf("vec%0d.pc_we", i),    {31'd0, c_pcwe},  {31'd0, vq[i].e_pcwe});
            chk($sformatf("vec%0d.I2", i), I2, vq[i].e2);
            chk($sformatf("vec%0d.I3", i), I3, vq[i].e3);
            chk($sformatf("vec%0d.I4", i), I4, vq[i].e4);
            chk($sformatf("vec%0d.I5", i), I5, vq[i].e5);
            chk($sformatf("vec%0d.stall_cnt", i), {16'd0, stall_cnt}, 32'(vq[i].e_sc));
            chk($sformatf("vec%0d.flush_cnt", i), {16'd0, flush_cnt}, 32'(vq[i].e_fc));
        end

        // 20 load-use events: 4-bit counter saturates, 16-bit counter keeps counting.
        for (int e = 0; e < 20; e++) begin
            do_cycle(1'b0, LW5, 1'b1, 1'b1, 1'b0);
            do_cycle(1'b0, ADD, 1'b1, 1'b1, 1'b0);
            do_cycle(1'b0, JNK, 1'b0, 1'b1, 1'b0);
            chk("sat.stall_lu", {31'd0, c_stall}, 32'd1);
        end
        chk("sat.stall_cnt4", {28'd0, s_stall_cnt}, 32'h0000000F);
        chk("sat.stall_cnt16", {16'd0, stall_cnt}, 32'd21);
        chk("sat.I4", I4, LW5);

        // Reset mid-stream, even with a flush and a fresh instruction offered.
        do_cycle(1'b1, LW5, 1'b1, 1'b1, 1'b1);
        chk("midrst.I2", I2, NOP);
        chk("midrst.I3", I3, NOP);
        chk("midrst.I4", I4, NOP);
        chk("midrst.I5", I5, NOP);
        chk("midrst.stall_cnt4", {28'd0, s_stall_cnt}, 32'd0);
        chk("midrst.stall_cnt16", {16'd0, stall_cnt}, 32'd0);
        chk("midrst.flush_cnt16", {16'd0, flush_cnt}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            do_cycle($urandom_range(0, 199) == 0,
                     rand_inst(),
                     $urandom_range(0, 99) < 85,
                     $urandom_range(0, 99) < 80,
                     $urandom_range(0, 99) < 10);
            chk_model($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
